// File: rtl/btn_debounce.sv
// btn_debounce: per-button 2-flop synchronizer, debounce FSM and press/release/long-press pulses.
// Define BTN_LONG_PRESS_EN to build in long-press detection; without it btn_long is tied low.
module btn_debounce #(
    parameter int N_BTN           = 2,
    parameter int DEBOUNCE_CYCLES = 270_000,
    parameter int LONG_CYCLES     = 27_000_000,
    parameter int CNT_W           = 25
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_long
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`else
    logic unused_long_cfg;
    assign unused_long_cfg = (LONG_CYCLES > DEBOUNCE_CYCLES);
`endif

    // Synchronizer stages; pins idle high, so reset to the released value
    logic [N_BTN-1:0] sync_p0;
    logic [N_BTN-1:0] sync_p1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_p0 <= '1;
            sync_p1 <= '1;
        end else begin
            sync_p0 <= btn_raw;
            sync_p1 <= sync_p0;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             level_r;
        logic             press_r;
        logic             release_r;
        logic             pressed;
`ifdef BTN_LONG_PRESS_EN
        logic             long_r;
        logic             long_done;
`endif

        assign pressed = ~sync_p1[i];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                state     <= IDLE;
                cnt       <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                long_r    <= 1'b0;
                long_done <= 1'b0;
`endif
            end else begin
                press_r   <= 1'b0;
                release_r <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
                long_r    <= 1'b0;
`endif
                case (state)
                    IDLE: begin
                        if (pressed) begin
                            state <= PRESS_WAIT;
                            cnt   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!pressed) begin
                            state <= IDLE;
                        end else if (cnt == DEB_LAST) begin
                            state     <= HELD;
                            level_r   <= 1'b1;
                            press_r   <= 1'b1;
                            cnt       <= '0;
`ifdef BTN_LONG_PRESS_EN
                            long_done <= 1'b0;
`endif
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        if (!pressed) begin
                            state <= RELEASE_WAIT;
                            cnt   <= '0;
                        end
`ifdef BTN_LONG_PRESS_EN
                        // Counter parks at LONG_LAST once fired: one pulse per hold, no wrap
                        else if (!long_done) begin
                            if (cnt == LONG_LAST) begin
                                long_r    <= 1'b1;
                                long_done <= 1'b1;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
`endif
                    end
                    RELEASE_WAIT: begin
                        // A bounce back to pressed keeps long_done, so a fired long press never re-arms
                        if (pressed) begin
                            state <= HELD;
                            cnt   <= '0;
                        end else if (cnt == DEB_LAST) begin
                            state     <= IDLE;
                            level_r   <= 1'b0;
                            release_r <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign btn_level[i]   = level_r;
        assign btn_press[i]   = press_r;
        assign btn_release[i] = release_r;
`ifdef BTN_LONG_PRESS_EN
        assign btn_long[i]    = long_r;
`else
        assign btn_long[i]    = 1'b0;
`endif
    end

endmodule

// File: tb/tb_btn_debounce.sv
// Directed bench for btn_debounce with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, N_BTN=2.
// Long-press expectations follow whether BTN_LONG_PRESS_EN is defined for the build.
module tb_btn_debounce;

    localparam int N_BTN = 2;
    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int CNT_W = 5;
`ifdef BTN_LONG_PRESS_EN
    localparam logic LONG_EN = 1'b1;
`else
    localparam logic LONG_EN = 1'b0;
`endif

    logic             sys_clk;
    logic             sys_rst_n;
    logic [N_BTN-1:0] btn_raw;
    logic [N_BTN-1:0] btn_level;
    logic [N_BTN-1:0] btn_press;
    logic [N_BTN-1:0] btn_release;
    logic [N_BTN-1:0] btn_long;

    int total = 0;
    int bad   = 0;

    btn_debounce #(
        .N_BTN          (N_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (CNT_W)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] lvl, input logic [1:0] prs,
                           input logic [1:0] rel, input logic [1:0] lng);
        chk({tag, "_level"},   {6'd0, btn_level},   {6'd0, lvl});
        chk({tag, "_press"},   {6'd0, btn_press},   {6'd0, prs});
        chk({tag, "_release"}, {6'd0, btn_release}, {6'd0, rel});
        chk({tag, "_long"},    {6'd0, btn_long},    {6'd0, lng});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst_n = 1'b0;
        btn_raw   = 2'b11;
        tick();
        tick();
        chk_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
        sys_rst_n = 1'b1;
        tick();
        tick();
        chk_all("idle", 2'b00, 2'b00, 2'b00, 2'b00);

        // Bounce rejection: 3 low / 3 high, five times
        for (int r = 0; r < 5; r++) begin
            btn_raw[0] = 1'b0;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk_all("bounce_lo", 2'b00, 2'b00, 2'b00, 2'b00);
            end
            btn_raw[0] = 1'b1;
            for (int k = 0; k < 3; k++) begin
                tick();
                chk_all("bounce_hi", 2'b00, 2'b00, 2'b00, 2'b00);
            end
        end
        tick();
        tick();

        // Clean press held 40 cycles: press at edge 7, long at edge 27
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 40; e++) begin
            tick();
            chk_all("clean",
                    {1'b0, e >= 7},
                    {1'b0, e == 7},
                    2'b00,
                    {1'b0, (e == 27) && LONG_EN});
        end

        // Release with bounce: high 2, low 1, then high
        btn_raw[0] = 1'b1;
        tick();
        chk_all("rel_b1", 2'b01, 2'b00, 2'b00, 2'b00);
        tick();
        chk_all("rel_b2", 2'b01, 2'b00, 2'b00, 2'b00);
        btn_raw[0] = 1'b0;
        tick();
        chk_all("rel_b3", 2'b01, 2'b00, 2'b00, 2'b00);
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            tick();
            chk_all("rel",
                    {1'b0, e < 7},
                    2'b00,
                    {1'b0, e == 7},
                    2'b00);
        end

        // Reset mid-hold
        btn_raw[0] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
        end
        chk_all("pre_rst", 2'b01, 2'b01, 2'b00, 2'b00);
        #2;
        sys_rst_n = 1'b0;
        #1;
        chk_all("rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
        tick();
        chk_all("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
        sys_rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all("post_rst",
                    {1'b0, e >= 7},
                    {1'b0, e == 7},
                    2'b00,
                    2'b00);
        end
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all("post_rst_rel",
                    {1'b0, e < 7},
                    2'b00,
                    {1'b0, e == 7},
                    2'b00);
        end

        // Simultaneous press, then release of button 1 only
        btn_raw = 2'b00;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all("sim_press",
                    (e >= 7) ? 2'b11 : 2'b00,
                    (e == 7) ? 2'b11 : 2'b00,
                    2'b00,
                    2'b00);
        end
        btn_raw[1] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all("sim_rel1",
                    (e >= 7) ? 2'b01 : 2'b11,
                    2'b00,
                    (e == 7) ? 2'b10 : 2'b00,
                    2'b00);
        end
        btn_raw[0] = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            chk_all("sim_rel0",
                    (e >= 7) ? 2'b00 : 2'b01,
                    2'b00,
                    (e == 7) ? 2'b01 : 2'b00,
                    2'b00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_debounce.md
# btn_debounce

Per-button synchronizer, debouncer and event generator for the board push-buttons. It sits directly upstream of the LED pattern logic. It turns raw, bouncing, active-low button pins into clean active-high levels and single-cycle press, release and long-press pulses, all in the `sys_clk` domain. Downstream blocks consume these pulses instead of using raw pins as resets or direction controls.

## Interface
- `N_BTN`, 2 — number of independent buttons.
- `DEBOUNCE_CYCLES`, 270_000 — stable cycles required to accept a level change (10 ms at 27 MHz); ≥ 2.
- `LONG_CYCLES`, 27_000_000 — hold cycles after an accepted press before the long-press pulse (1 s at 27 MHz); > `DEBOUNCE_CYCLES`.
- `CNT_W`, 25 — per-button counter width; must hold `max(DEBOUNCE_CYCLES, LONG_CYCLES) - 1`.
- `sys_clk  in  1` — system clock, 27 MHz.
- `sys_rst_n  in  1` — asynchronous, active-low reset.
- `btn_raw  in  N_BTN` — raw pins, asynchronous, active-low (0 = pressed).
- `btn_level  out  N_BTN` — debounced state, 1 = pressed.
- `btn_press  out  N_BTN` — 1-cycle pulse on accepted press.
- `btn_release  out  N_BTN` — 1-cycle pulse on accepted release.
- `btn_long  out  N_BTN` — 1-cycle pulse when a press is held `LONG_CYCLES`.

## Operation
- Each button has its own logic; there is no cross-coupling.
- Synchronizer: two flops per bit, reset to 1 (released). `p = ~sync2` is the synchronized pressed signal.
- The per-button FSM has states IDLE, PRESS_WAIT, HELD and RELEASE_WAIT, plus a counter `cnt[CNT_W-1:0]` and a `long_done` flag.
  - **IDLE:** when `p` = 1, go to PRESS_WAIT with `cnt` = 0.
  - **PRESS_WAIT:** when `p` = 0, go to IDLE with no output (bounce rejected). Otherwise `cnt++`. When `cnt == DEBOUNCE_CYCLES-1` and `p` = 1, go to HELD: set `btn_level` = 1, pulse `btn_press`, set `cnt` = 0 and `long_done` = 0.
  - **HELD:** when `p` = 0, go to RELEASE_WAIT with `cnt` = 0. Otherwise, while `long_done` = 0, `cnt++`. When `cnt == LONG_CYCLES-1`, pulse `btn_long` and set `long_done` = 1. `cnt` then holds, so there is no repeat and no wrap.
  - **RELEASE_WAIT:** when `p` = 1, go back to HELD with `cnt` = 0 and `long_done` unchanged. A bounce does not re-arm the long press; if the long press has not fired, the hold timing restarts. Otherwise `cnt++`. When `cnt == DEBOUNCE_CYCLES-1`, go to IDLE: set `btn_level` = 0 and pulse `btn_release`.
- All outputs are registered.
- `btn_press` and `btn_release` are mutually exclusive per button.
- `btn_long` can never coincide with `btn_press`.

## Timing
- Reset values:
  - all outputs 0;
  - FSM in IDLE;
  - `cnt` = 0;
  - synchronizer flops = 1.
- Reset mid-operation clears everything immediately, with no release pulse. After reset is deasserted, a button still held is treated as a new press.
- Press latency: if the first `sys_clk` edge samples `btn_raw` = 0 at edge 1, then `btn_press` and `btn_level` rise after edge `DEBOUNCE_CYCLES + 3`, provided the pin stays low throughout.
- Release latency is the same: `DEBOUNCE_CYCLES + 3` edges from the first sampled 1.
- Long press: `btn_long` is high exactly `LONG_CYCLES` cycles after `btn_press` for an uninterrupted hold.
- Any bounce shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no event.
- Pulses are exactly 1 `sys_clk` cycle wide.

## Configuration
- `BTN_LONG_PRESS_EN` defined: long-press counting in HELD, `long_done` and `btn_long` behave as described above.
- `BTN_LONG_PRESS_EN` not defined:
  - `btn_long` is tied to 0;
  - HELD does not count;
  - `long_done` is removed;
  - `LONG_CYCLES` is ignored, and `CNT_W` need only cover `DEBOUNCE_CYCLES - 1`.
- Press, release and level behaviour is identical in both builds.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `LONG_CYCLES` = 20, `N_BTN` = 2, macro defined unless stated.
- **Clean press:** `btn_raw[0]` goes 0 and is held 40 cycles → `btn_press[0]` high for 1 cycle after edge 7, `btn_level[0]` = 1 from then, `btn_long[0]` exactly 20 cycles after `btn_press[0]` and only once.
- **Bounce rejection:** `btn_raw[0]` low for 3 cycles then high, repeated 5 times → no pulses, `btn_level[0]` stays 0.
- **Release with bounce:** from HELD, `btn_raw[0]` high 2 cycles, low 1, then high → a single `btn_release[0]` pulse 7 edges after the final rising edge is sampled, `btn_level[0]` = 0, no extra `btn_press`.
- **Reset mid-hold:** `sys_rst_n` pulsed low while `btn_level[0]` = 1 → all outputs 0 immediately, no `btn_release`. With the button still held after deassertion → new `btn_press[0]` 7 edges later.
- **Simultaneous buttons:** both bits go low on the same cycle → `btn_press[1:0]` = 2'b11 on the same cycle. Release only bit 1 → `btn_release[1]` only, bit 0 unaffected.
- **Macro undefined:** hold 40 cycles → `btn_long` stays 0 throughout, press and release timing identical to the first scenario.
